mem_arbiter: RTL and testbench

- Sequences the single shared, multi-cycle unified memory between two requesters: the fetch stage (instruction reads only) and the memory stage (data reads and writes).
- Issues at most one access at a time and counts the fixed memory latency.
- Returns read data and a one-cycle done pulse to the owning requester.
- Drives per-requester stall outputs for the pipeline hazard logic.
- Data has priority over fetch, with a bounded-starvation guarantee for fetch.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter for the shared multi-cycle unified memory between the fetch and data stages.
// Data wins collisions, but a pending fetch is served after at most MAX_DWIN consecutive data grants.
module mem_arbiter #(
  parameter int LAT      = 4,
  parameter int MAX_DWIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
  localparam logic [3:0] DWIN_MAX = 4'(MAX_DWIN);

  state_t     r_state, w_state_nxt;
  owner_t     r_owner, w_owner_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_dwin, w_dwin_nxt;
  logic       r_wr, w_wr_nxt;
  logic       w_idle, w_grant_d, w_grant_if, w_fin;

  assign w_idle     = (r_state == ST_IDLE);
  // Data takes the slot unless fetch has already waited out MAX_DWIN data grants.
  assign w_grant_d  = w_idle & d_req & ~(if_req & (r_dwin == DWIN_MAX));
  assign w_grant_if = w_idle & if_req & ~w_grant_d;
  assign w_fin      = (r_state == ST_BUSY) & (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_cnt   <= 4'd0;
      r_dwin  <= 4'd0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dwin  <= w_dwin_nxt;
      r_wr    <= w_wr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_dwin_nxt  = r_dwin;
    w_wr_nxt    = r_wr;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = OWN_D;
          w_cnt_nxt   = CNT_INIT;
          w_wr_nxt    = d_wr;
          if (!if_req)                 w_dwin_nxt = 4'd0;
          else if (r_dwin == DWIN_MAX) w_dwin_nxt = DWIN_MAX;
          else                         w_dwin_nxt = r_dwin + 4'd1;
        end else if (w_grant_if) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = OWN_IF;
          w_cnt_nxt   = CNT_INIT;
          w_wr_nxt    = 1'b0;
          w_dwin_nxt  = 4'd0;
        end
      end
      ST_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_NONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  assign mem_en    = w_grant_d | w_grant_if;
  assign mem_wr    = w_grant_d & d_wr;
  assign mem_addr  = w_grant_d ? d_addr : (w_grant_if ? if_addr : 16'h0000);
  assign mem_wdata = w_grant_d ? d_wdata : 16'h0000;

  // Read data is a pass-through of memory in the owner's done cycle only.
  assign if_done   = w_fin & (r_owner == OWN_IF);
  assign d_done    = w_fin & (r_owner == OWN_D);
  assign if_rdata  = if_done ? mem_rdata : 16'h0000;
  assign d_rdata   = (d_done & ~r_wr) ? mem_rdata : 16'h0000;
  assign if_stall  = if_req & ~if_done;
  assign d_stall   = d_req & ~d_done;
  assign busy      = (r_state == ST_BUSY);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and a random run against
// a cycle-numbered transaction model. dut0 uses LAT=4/MAX_DWIN=4, dut1 uses LAT=1.
module tb_mem_arbiter;
  localparam int LAT  = 4;
  localparam int MAXD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req, d_req, d_wr;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;

  typedef struct packed {
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        if_stall;
    logic        d_stall;
    logic        busy;
  } out_t;

  logic        en0, wr0, ifd0, dd0, ifs0, ds0, bsy0;
  logic [15:0] ma0, mwd0, ird0, drd0;
  logic        en1, wr1, ifd1, dd1, ifs1, ds1, bsy1;
  logic [15:0] ma1, mwd1, ird1, drd1;
  out_t a0, a1;
  assign a0 = {en0, wr0, ma0, mwd0, ifd0, ird0, dd0, drd0, ifs0, ds0, bsy0};
  assign a1 = {en1, wr1, ma1, mwd1, ifd1, ird1, dd1, drd1, ifs1, ds1, bsy1};

  mem_arbiter #(.LAT(LAT), .MAX_DWIN(MAXD)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(ifd0), .if_rdata(ird0), .if_stall(ifs0),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(dd0), .d_rdata(drd0), .d_stall(ds0),
    .mem_en(en0), .mem_wr(wr0), .mem_addr(ma0), .mem_wdata(mwd0), .mem_rdata(mem_rdata),
    .busy(bsy0)
  );

  mem_arbiter #(.LAT(1), .MAX_DWIN(MAXD)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(ifd1), .if_rdata(ird1), .if_stall(ifs1),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(dd1), .d_rdata(drd1), .d_stall(ds1),
    .mem_en(en1), .mem_wr(wr1), .mem_addr(ma1), .mem_wdata(mwd1), .mem_rdata(mem_rdata),
    .busy(bsy1)
  );

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic        ifr;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dwd;
    logic [15:0] mrd;
    out_t        e;
  } vec_t;
  vec_t vt[$];

  function automatic out_t ex(logic en, logic wr, logic [15:0] ma, logic [15:0] mwd,
                              logic ifd, logic [15:0] ird, logic dd, logic [15:0] drd,
                              logic ifs, logic ds, logic bsy);
    return {en, wr, ma, mwd, ifd, ird, dd, drd, ifs, ds, bsy};
  endfunction

  task automatic addv(input logic ifr, input logic [15:0] ia, input logic dr, input logic dw,
                      input logic [15:0] da, input logic [15:0] dwd, input logic [15:0] mrd,
                      input out_t e);
    vec_t v;
    v.ifr = ifr; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.mrd = mrd; v.e = e;
    vt.push_back(v);
  endtask

  task automatic drive(input logic ifr, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] dwd, input logic [15:0] mrd);
    if_req = ifr; if_addr = ia; d_req = dr; d_wr = dw; d_addr = da; d_wdata = dwd; mem_rdata = mrd;
  endtask

  task automatic chk(input string nm, input out_t act, input out_t exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  // Transaction-level reference: an access issued in cycle t completes in cycle t+LAT.
  int m_t, m_done_t, m_own, m_dwin;
  bit m_busy, m_wr, p_ifd, p_dd;

  task automatic model(output out_t e);
    e = '0;
    e.busy = m_busy;
    if (m_busy) begin
      if (m_t == m_done_t) begin
        if (m_own == 1) begin
          e.if_done = 1'b1;
          e.if_rdata = mem_rdata;
        end else begin
          e.d_done = 1'b1;
          e.d_rdata = m_wr ? 16'h0000 : mem_rdata;
        end
        m_busy = 1'b0;
      end
    end else if (if_req || d_req) begin
      if (d_req && !(if_req && m_dwin == MAXD)) begin
        e.mem_en = 1'b1; e.mem_wr = d_wr; e.mem_addr = d_addr; e.mem_wdata = d_wdata;
        m_own = 2; m_wr = d_wr;
        m_dwin = if_req ? ((m_dwin + 1 > MAXD) ? MAXD : m_dwin + 1) : 0;
      end else begin
        e.mem_en = 1'b1; e.mem_addr = if_addr;
        m_own = 1; m_wr = 1'b0; m_dwin = 0;
      end
      m_busy = 1'b1;
      m_done_t = m_t + LAT;
    end
    e.if_stall = if_req && !e.if_done;
    e.d_stall  = d_req && !e.d_done;
    p_ifd = e.if_done;
    p_dd  = e.d_done;
    m_t++;
  endtask

  initial begin
    out_t e;
    logic [15:0] iq[$];
    logic [15:0] sexp[6];

    // Fetch alone
    addv(1, 16'h0010, 0, 0, 0, 0, 0,        ex(1, 0, 16'h0010, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      addv(1, 16'hFFFF, 0, 0, 0, 0, 0,      ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    addv(1, 16'hFFFF, 0, 0, 0, 0, 16'hC0DE, ex(0, 0, 0, 0, 1, 16'hC0DE, 0, 0, 0, 0, 1));
    addv(0, 0, 0, 0, 0, 0, 16'h1111,        ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Collision: data write first, then fetch
    addv(1, 16'h0040, 1, 1, 16'h0200, 16'h1234, 0, ex(1, 1, 16'h0200, 16'h1234, 0, 0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 3; i++)
      addv(1, 16'h0040, 1, 1, 16'hDEAD, 16'hBEEF, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    addv(1, 16'h0040, 1, 1, 16'hDEAD, 16'hBEEF, 16'h9999, ex(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    addv(1, 16'h0040, 0, 0, 0, 16'h1234, 0,  ex(1, 0, 16'h0040, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      addv(1, 16'h0040, 0, 0, 0, 0, 0,       ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    addv(1, 16'h0040, 0, 0, 0, 0, 16'h5A5A,  ex(0, 0, 0, 0, 1, 16'h5A5A, 0, 0, 0, 0, 1));
    addv(0, 0, 0, 0, 0, 0, 0,                ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Data read alone
    addv(0, 0, 1, 0, 16'h0300, 0, 0,         ex(1, 0, 16'h0300, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      addv(0, 0, 1, 0, 16'h0300, 0, 0,       ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    addv(0, 0, 1, 0, 16'h0300, 0, 16'hABCD,  ex(0, 0, 0, 0, 0, 0, 1, 16'hABCD, 0, 0, 1));
    addv(0, 0, 0, 0, 0, 0, 16'hABCD,         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_reset();
    smp(); chk("reset0", a0, '0); chk("reset1", a1, '0); nxt();

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].ifr, vt[i].ia, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dwd, vt[i].mrd);
      smp(); chk($sformatf("vec%0d", i), a0, vt[i].e); nxt();
    end

    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0, 16'($urandom));
      smp(); chk("idle0", a0, '0); chk("idle1", a1, '0); nxt();
    end

    // Reset mid-access, requester drops
    do_reset();
    drive(0, 0, 1, 0, 16'h0300, 0, 0);
    smp(); chk("rst_iss", a0, ex(1, 0, 16'h0300, 0, 0, 0, 0, 0, 0, 1, 0)); nxt();
    smp(); chk("rst_busy", a0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); nxt();
    rst = 1'b1;
    smp(); chk("rst_busy2", a0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); nxt();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 16'hEEEE);
    for (int i = 3; i < 9; i++) begin
      smp(); chk("rst_idle", a0, '0); nxt();
    end

    // Reset mid-access, requester re-presents right after reset
    drive(0, 0, 1, 0, 16'h0300, 0, 0);
    smp(); chk("rst2_iss", a0, ex(1, 0, 16'h0300, 0, 0, 0, 0, 0, 0, 1, 0)); nxt();
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    drive(0, 0, 1, 0, 16'h0304, 0, 16'h4242);
    smp(); chk("rst2_reiss", a0, ex(1, 0, 16'h0304, 0, 0, 0, 0, 0, 0, 1, 0)); nxt();
    for (int i = 0; i < 3; i++) begin
      smp(); chk("rst2_busy", a0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); nxt();
    end
    smp(); chk("rst2_done", a0, ex(0, 0, 0, 0, 0, 0, 1, 16'h4242, 0, 0, 1)); nxt();
    drive(0, 0, 0, 0, 0, 0, 0);

    // Starvation bound
    do_reset();
    drive(1, 16'h1000, 1, 0, 16'h2000, 0, 0);
    for (int i = 0; i < 30; i++) begin
      smp();
      if (en0) iq.push_back(ma0);
      nxt();
    end
    sexp = '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h1000, 16'h2000};
    chki("starve_cnt", iq.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < iq.size()) chki($sformatf("starve_grant%0d", k), int'(iq[k]), int'(sexp[k]));

    // LAT=1 back-to-back fetches
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1, 16'((c >> 1) * 2), 0, 0, 0, 0, 16'hA000 + 16'(c));
      if (c % 2 == 0) e = ex(1, 0, 16'((c >> 1) * 2), 0, 0, 0, 0, 0, 1, 0, 0);
      else            e = ex(0, 0, 0, 0, 1, 16'hA000 + 16'(c), 0, 0, 0, 0, 1);
      smp(); chk($sformatf("lat1_c%0d", c), a1, e); nxt();
    end

    // Random traffic against the model
    do_reset();
    m_t = 0; m_busy = 0; m_dwin = 0; m_own = 0; m_wr = 0; m_done_t = 0; p_ifd = 0; p_dd = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!if_req) begin
        if ($urandom_range(2) == 0) begin if_req = 1'b1; if_addr = 16'($urandom); end
      end else if (p_ifd) begin
        if ($urandom_range(1) == 0) if_req = 1'b0;
        else if_addr = 16'($urandom);
      end else if ($urandom_range(3) == 0) if_addr = 16'($urandom);
      if (!d_req) begin
        if ($urandom_range(2) == 0) begin
          d_req = 1'b1; d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
      end else if (p_dd) begin
        if ($urandom_range(1) == 0) d_req = 1'b0;
        else begin d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom); end
      end else if ($urandom_range(3) == 0) begin
        d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      mem_rdata = 16'($urandom);
      model(e);
      smp(); chk("rand", a0, e); nxt();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
